operand2_stage: RTL and testbench

- Registered, parametrised generator for the second source operand (N) of the SPARC integer datapath. Sits between instruction decode and the ALU/branch-target adder.
- Covers every V8 operand-2 form: register, sign-extended simm13, SETHI, shift count, disp22 and disp30.
- Buffers results in a DEPTH-entry FIFO with valid/ready handshakes on both sides, a flush input and an illegal-encoding counter.

---
 rtl/operand2_stage.sv | 184 ++++++++++++++++++
 tb/tb_operand2_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand2_stage.sv
// operand2_stage: decodes the SPARC operand-2 value (N) from the instruction word and rs2,
// and buffers it in a DEPTH-entry valid/ready FIFO with flush and an illegal-encoding counter.
`default_nettype none

module operand2_stage #(
  parameter  int DATA_W   = 32,
  parameter  int SHAMT_W  = 5,
  parameter  int DEPTH    = 2,
  parameter  int ERRCNT_W = 8,
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [DATA_W-1:0]   in_rs2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_n,
  output logic [2:0]          out_mode,
  output logic                out_err,
  output logic [CNT_W-1:0]    count,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [2:0] MODE_REG    = 3'd0;
  localparam logic [2:0] MODE_SIMM13 = 3'd1;
  localparam logic [2:0] MODE_SETHI  = 3'd2;
  localparam logic [2:0] MODE_SHIFT  = 3'd3;
  localparam logic [2:0] MODE_DISP22 = 3'd4;
  localparam logic [2:0] MODE_DISP30 = 3'd5;
  localparam logic [2:0] MODE_ILLEGAL = 3'd7;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // Instruction fields
  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic       imm_sel;

  assign op      = in_instr[31:30];
  assign op2     = in_instr[24:22];
  assign op3     = in_instr[24:19];
  assign imm_sel = in_instr[13];

  logic [DATA_W-1:0] sethi_val;
  logic [DATA_W-1:0] disp22_val;
  logic [DATA_W-1:0] disp30_val;
  logic [DATA_W-1:0] simm13_val;
  logic [DATA_W-1:0] shamt_val;
  logic [SHAMT_W-1:0] shamt_src;
  logic               is_shift;

  assign sethi_val  = DATA_W'({in_instr[21:0], 10'b0});
  assign disp22_val = DATA_W'($signed(in_instr[21:0])) << 2;
  assign disp30_val = DATA_W'($signed(in_instr[29:0])) << 2;
  assign simm13_val = DATA_W'($signed(in_instr[12:0]));
  assign shamt_src  = imm_sel ? in_instr[SHAMT_W-1:0] : in_rs2[SHAMT_W-1:0];
  assign shamt_val  = DATA_W'(shamt_src);
  assign is_shift   = (op3 == 6'b100101) || (op3 == 6'b100110) || (op3 == 6'b100111);

  logic [DATA_W-1:0] dec_n;
  logic [2:0]        dec_mode;
  logic              dec_err;

  always_comb begin
    dec_n    = '0;
    dec_mode = MODE_REG;
    dec_err  = 1'b0;
    case (op)
      2'b00: begin
        if (op2 == 3'b100) begin
          dec_n    = sethi_val;
          dec_mode = MODE_SETHI;
        end else if ((op2 == 3'b010) || (op2 == 3'b110)) begin
          dec_n    = disp22_val;
          dec_mode = MODE_DISP22;
        end else begin
          dec_n    = '0;
          dec_mode = MODE_ILLEGAL;
          dec_err  = 1'b1;
        end
      end
      2'b01: begin
        dec_n    = disp30_val;
        dec_mode = MODE_DISP30;
      end
      default: begin
        // Shift decoding applies only to the arithmetic (op=10) group
        if ((op == 2'b10) && is_shift) begin
          dec_n    = shamt_val;
          dec_mode = MODE_SHIFT;
        end else if (imm_sel) begin
          dec_n    = simm13_val;
          dec_mode = MODE_SIMM13;
        end else begin
          dec_n    = in_rs2;
          dec_mode = MODE_REG;
        end
      end
    endcase
  end

  logic [CNT_W-1:0]    count_q,  count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [DATA_W-1:0] mem_n_q    [DEPTH];
  logic [2:0]        mem_mode_q [DEPTH];
  logic              mem_err_q  [DEPTH];

  logic push;
  logic pop;

  assign in_ready  = (count_q < FULL_CNT) && !reset;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_cnt_d = err_cnt_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (dec_err && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage is not reset; outputs are masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_n_q[wr_ptr_q]    <= dec_n;
      mem_mode_q[wr_ptr_q] <= dec_mode;
      mem_err_q[wr_ptr_q]  <= dec_err;
    end
  end

  assign out_n     = out_valid ? mem_n_q[rd_ptr_q]    : '0;
  assign out_mode  = out_valid ? mem_mode_q[rd_ptr_q] : 3'd0;
  assign out_err   = out_valid ? mem_err_q[rd_ptr_q]  : 1'b0;
  assign count     = count_q;
  assign err_count = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_operand2_stage.sv
// tb_operand2_stage: directed and randomized checks of operand2_stage against a queue-based model.
`default_nettype none

module tb_operand2_stage;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] n;
    logic [2:0]  mode;
    logic        err;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_n;
  logic [2:0]  out_mode;
  logic        out_err;
  logic [1:0]  count;
  logic [7:0]  err_count;

  int checks = 0;
  int passes = 0;

  operand2_stage #(.DATA_W(32), .SHAMT_W(5), .DEPTH(DEPTH), .ERRCNT_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs2(in_rs2), .out_valid(out_valid), .out_ready(out_ready),
    .out_n(out_n), .out_mode(out_mode), .out_err(out_err), .count(count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference decode written directly from the operand-2 rules using integer arithmetic
  function automatic entry_t ref_decode(input logic [31:0] ins, input logic [31:0] rs2);
    entry_t e;
    int unsigned op, op2, op3;
    longint v;
    op  = ins[31:30];
    op2 = ins[24:22];
    op3 = ins[24:19];
    e = '0;
    if (op == 0) begin
      if (op2 == 4) begin
        e.n = 32'(longint'(ins[21:0]) * 1024); e.mode = 3'd2;
      end else if (op2 == 2 || op2 == 6) begin
        v = longint'(ins[21:0]);
        if (ins[21]) v = v - 4194304;
        e.n = 32'(v * 4); e.mode = 3'd4;
      end else begin
        e.n = 0; e.mode = 3'd7; e.err = 1'b1;
      end
    end else if (op == 1) begin
      v = longint'(ins[29:0]);
      if (ins[29]) v = v - 1073741824;
      e.n = 32'(v * 4); e.mode = 3'd5;
    end else if (op == 2 && (op3 == 37 || op3 == 38 || op3 == 39)) begin
      e.n = (ins[13] ? ins : rs2) % 32; e.mode = 3'd3;
    end else if (ins[13]) begin
      v = longint'(ins[12:0]);
      if (ins[12]) v = v - 8192;
      e.n = 32'(v); e.mode = 3'd1;
    end else begin
      e.n = rs2; e.mode = 3'd0;
    end
    return e;
  endfunction

  entry_t q[$];
  int     m_errcnt = 0;

  always @(posedge clk) begin
    bit m_push, m_pop;
    entry_t e;
    if (reset) begin
      q.delete();
      m_errcnt = 0;
    end else begin
      m_push = in_valid && (q.size() < DEPTH);
      m_pop  = (q.size() != 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) begin
          e = ref_decode(in_instr, in_rs2);
          q.push_back(e);
          if (e.err && m_errcnt < 255) m_errcnt++;
        end
      end
    end
  end

  always @(posedge clk) begin
    entry_t h;
    #1;
    h = (q.size() != 0) ? q[0] : '0;
    chk("m_in_ready", 64'(in_ready), 64'((q.size() < DEPTH) && !reset));
    chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("m_count", 64'(count), 64'(q.size()));
    chk("m_err_count", 64'(err_count), 64'(m_errcnt));
    chk("m_out_n", 64'(out_n), 64'(h.n));
    chk("m_out_mode", 64'(out_mode), 64'(h.mode));
    chk("m_out_err", 64'(out_err), 64'(h.err));
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push1(input logic [31:0] ins, input logic [31:0] rs2);
    int n = 0;
    in_instr = ins; in_rs2 = rs2; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("push_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [31:0] n, input logic [2:0] mode, input logic err);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_n"}, 64'(out_n), 64'(n));
    chk({name, "_mode"}, 64'(out_mode), 64'(mode));
    chk({name, "_err"}, 64'(out_err), 64'(err));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {2'b00, r[29:0]};
      1: return {2'b00, r[29:25], 3'b100, r[21:0]};
      2: return {2'b00, r[29:25], r[0] ? 3'b010 : 3'b110, r[21:0]};
      3: return {2'b01, r[29:0]};
      4: return {2'b10, r[29:25], 6'(37 + $urandom_range(0, 2)), r[18:0]};
      default: return {1'b1, r[30:0]};
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_out_n", 64'(out_n), 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    push1(32'h033FFFFF, 32'h0);        chk_head("sethi", 32'hFFFFFC00, 3'd2, 1'b0);
    push1(32'h80003FFF, 32'h12345678); chk_head("simm13", 32'hFFFFFFFF, 3'd1, 1'b0);
    push1(32'h80000000, 32'h12345678); chk_head("reg", 32'h12345678, 3'd0, 1'b0);
    push1(32'h81280000, 32'hDEADBEEF); chk_head("sll", 32'h0000000F, 3'd3, 1'b0);
    push1(32'h7FFFFFFF, 32'h0);        chk_head("call", 32'hFFFFFFFC, 3'd5, 1'b0);
    push1(32'h00A00000, 32'h0);        chk_head("bicc", 32'hFF800000, 3'd4, 1'b0);
    @(negedge clk);

    // Backpressure: three offers into a two-entry buffer
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h80002001; @(negedge clk);
    in_instr = 32'h80002002; @(negedge clk);
    in_instr = 32'h80002003;
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_full_count", 64'(count), 64'd2);
    @(negedge clk);
    chk("bp_held_count", 64'(count), 64'd2);
    chk_head("bp_head0", 32'd1, 3'd1, 1'b0);
    out_ready = 1'b1; @(negedge clk);
    chk("bp_pop1_count", 64'(count), 64'd1);
    chk_head("bp_head1", 32'd2, 3'd1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk_head("bp_head2", 32'd3, 3'd1, 1'b0);
    @(negedge clk);
    chk("bp_drained", 64'(count), 64'd0);

    push1(32'h00000000, 32'h0);        chk_head("unimp", 32'h0, 3'd7, 1'b1);
    chk("unimp_errcnt", 64'(err_count), 64'd1);
    @(negedge clk);

    // Flush with a simultaneous illegal push
    out_ready = 1'b0;
    push1(32'h80002005, 32'h0);
    push1(32'h80002006, 32'h0);
    in_valid = 1'b1; in_instr = 32'h00000000; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_errcnt", 64'(err_count), 64'd1);

    // Saturation
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00000000;
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    chk("sat_errcnt", 64'(err_count), 64'd255);
    @(negedge clk);

    // Randomized phase, model-checked every cycle
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      in_instr  = rand_instr();
      in_rs2    = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
